// File: rtl/dec_timer_pkg.sv
// Shared types and default widths for the dec_timer block.
package dec_timer_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefPreW  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHold
  } dec_timer_state_t;

endpackage

// File: rtl/dec_timer_if.sv
// Control/status bundle between a sequencer (master) and dec_timer (slave).
interface dec_timer_if
  import dec_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned PRE_W = DefPreW
);

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [PRE_W-1:0] prescale;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             expire;

  modport master (
    output load, load_val, prescale, start, stop,
    input  count, busy, expire
  );

  modport slave (
    input  load, load_val, prescale, start, stop,
    output count, busy, expire
  );

endinterface

// File: rtl/dec_timer_prescaler.sv
// Prescaler for dec_timer: counts RUN cycles and emits a tick once pre_cnt reaches prescale.
module dec_timer_prescaler
  import dec_timer_pkg::*;
#(
  parameter int unsigned PRE_W = DefPreW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             hold,
  input  logic             clear,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

  // >= rather than == so that lowering prescale mid-count fires at once instead of wrapping.
  assign tick = run & ~hold & (pre_cnt_q >= prescale);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clear) begin
      pre_cnt_d = '0;
    end else if (hold) begin
      pre_cnt_d = pre_cnt_q;
    end else if (run) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/dec_timer.sv
// Loadable down-counting timer with prescaler and one-cycle expiry pulse.
// Optional build macro DEC_TIMER_AUTO_RELOAD_EN: reload count on expiry and keep running.
module dec_timer
  import dec_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned PRE_W = DefPreW
) (
  input logic        clk,
  input logic        reset,
  dec_timer_if.slave bus
);

  dec_timer_state_t state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             expire_q, expire_d;
  logic [WIDTH-1:0] reload_val;
  logic [WIDTH-1:0] eff_count;
  logic             tick;

`ifdef DEC_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;

  assign reload_d   = bus.load ? bus.load_val : reload_q;
  assign reload_val = reload_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`else
  assign reload_val = '0;
`endif

  assign eff_count = bus.load ? bus.load_val : count_q;

  dec_timer_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .run      (state_q == StRun),
    .hold     (state_q == StHold),
    .clear    (bus.load | (state_q == StIdle)),
    .prescale (bus.prescale),
    .tick     (tick)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    expire_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.load) count_d = bus.load_val;
        if (bus.start && !bus.stop && (eff_count != '0)) state_d = StRun;
      end
      StRun: begin
        if (bus.load) begin
          // A load discards any tick this cycle.
          count_d = bus.load_val;
          if (bus.load_val == '0) begin
            state_d = StIdle;
          end else if (bus.stop) begin
            state_d = StHold;
          end
        end else if (count_q == '0) begin
          state_d = StIdle;
        end else begin
          if (tick) begin
            if (count_q == WIDTH'(1)) begin
              expire_d = 1'b1;
              count_d  = reload_val;
              if (reload_val == '0) state_d = StIdle;
            end else begin
              count_d = count_q - 1'b1;
            end
          end
          // Stop still honours a tick committed on the same edge.
          if (bus.stop && (state_d == StRun)) state_d = StHold;
        end
      end
      StHold: begin
        if (bus.load) count_d = bus.load_val;
        if (bus.stop) begin
          state_d = StIdle;
        end else if (bus.start) begin
          state_d = (eff_count != '0) ? StRun : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      busy_q   <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      expire_q <= expire_d;
    end
  end

  assign bus.count  = count_q;
  assign bus.busy   = busy_q;
  assign bus.expire = expire_q;

endmodule

// File: tb/tb_dec_timer.sv
// Self-checking bench for dec_timer: hand-derived expectations queued per cycle and checked after each edge.
module tb_dec_timer;

  localparam int unsigned W = 16;
  localparam int unsigned P = 8;

  typedef struct {
    string       tag;
    int unsigned cnt;
    bit          busy;
    bit          expire;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   n_total;
  int   n_bad;

  dec_timer_if #(.WIDTH(W), .PRE_W(P)) bus ();

  dec_timer #(.WIDTH(W), .PRE_W(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, clock, then pop and compare.
  task automatic step(input bit ld, input int unsigned lv, input int unsigned ps, input bit st,
                      input bit sp, input string tag, input int unsigned ec, input bit eb,
                      input bit ee);
    exp_t e;
    bus.load     = ld;
    bus.load_val = W'(lv);
    bus.prescale = P'(ps);
    bus.start    = st;
    bus.stop     = sp;
    e.tag = tag; e.cnt = ec; e.busy = eb; e.expire = ee;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_val({tag, "_sbdepth"}, sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_val({e.tag, "_cnt"}, 32'(bus.count), e.cnt);
      check_val({e.tag, "_busy"}, 32'(bus.busy), 32'(e.busy));
      check_val({e.tag, "_exp"}, 32'(bus.expire), 32'(e.expire));
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b0;
    bus.load = 1'b0; bus.load_val = '0; bus.prescale = '0; bus.start = 1'b0; bus.stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_cnt", 32'(bus.count), 0);
    check_val("rst_busy", 32'(bus.busy), 0);
    check_val("rst_exp", 32'(bus.expire), 0);
    @(negedge clk);
    reset = 1'b1;

`ifdef DEC_TIMER_AUTO_RELOAD_EN
    step(1, 2, 1, 1, 0, "ar_start", 2, 1, 0);
    for (int e = 1; e <= 12; e++) begin
      step(0, 0, 1, 0, 0, $sformatf("ar_e%0d", e),
           ((e % 4 == 2) || (e % 4 == 3)) ? 1 : 2, 1, (e % 4 == 0));
    end
    step(1, 0, 1, 0, 0, "ar_load0", 0, 0, 0);
`else
    // Basic countdown, prescale 0.
    step(1, 3, 0, 1, 0, "a_start", 3, 1, 0);
    step(0, 0, 0, 0, 0, "a_t1", 2, 1, 0);
    step(0, 0, 0, 0, 0, "a_t2", 1, 1, 0);
    step(0, 0, 0, 0, 0, "a_t3", 0, 0, 1);
    step(0, 0, 0, 0, 0, "a_post", 0, 0, 0);

    // Stop at edge 7, resume at edge 12; final tick at edge 15.
    step(1, 2, 4, 1, 0, "b_start", 2, 1, 0);
    for (int e = 1; e <= 16; e++) begin
      step(0, 0, 4, (e == 12), (e == 7), $sformatf("b_e%0d", e),
           (e < 5) ? 2 : ((e < 15) ? 1 : 0), (e < 15), (e == 15));
    end

    // Prescale lowered 10 -> 2 while pre_cnt is 6.
    step(1, 100, 10, 1, 0, "c_start", 100, 1, 0);
    for (int e = 1; e <= 14; e++) begin
      step(0, 0, (e >= 7) ? 2 : 10, 0, 0, $sformatf("c_e%0d", e),
           100 - int'(e >= 7) - int'(e >= 10) - int'(e >= 13), 1, 0);
    end
    step(0, 0, 2, 0, 1, "c_hold", 97, 1, 0);
    step(0, 0, 2, 0, 1, "c_cancel", 97, 0, 0);

    // Load 0 while running, start on zero count, start with load, load beats tick.
    step(1, 4, 10, 1, 0, "d_start", 4, 1, 0);
    step(1, 0, 10, 0, 0, "d_load0", 0, 0, 0);
    step(0, 0, 0, 1, 0, "d_start0", 0, 0, 0);
    step(1, 7, 0, 1, 0, "d_ldstart", 7, 1, 0);
    step(1, 9, 0, 0, 0, "d_ldtick", 9, 1, 0);
    for (int j = 1; j <= 9; j++) begin
      step(0, 0, 0, 0, 0, $sformatf("d_j%0d", j), 9 - j, (j < 9), (j == 9));
    end
    step(1, 5, 0, 1, 1, "d_stopprio", 5, 0, 0);

    // Asynchronous reset mid-run with count 5.
    step(0, 0, 3, 1, 0, "e_start", 5, 1, 0);
    step(0, 0, 3, 0, 0, "e_run", 5, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    check_val("e_async_cnt", 32'(bus.count), 0);
    check_val("e_async_busy", 32'(bus.busy), 0);
    check_val("e_async_exp", 32'(bus.expire), 0);
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0, 1, 0, "e_nostart", 0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dec_timer.md
# dec_timer

Loadable down-counting timer with programmable prescaler, run/hold/idle control and a single-cycle expiry pulse. It is the decrementing counterpart of the team's enable-gated up-counter registers: software or a sequencer loads a count, starts it, and receives `expire` when the count reaches zero. It sits beside the register bank as a timeout/interval source for control FSMs.

## Interface
Parameters:
- `WIDTH`, default 16: width of the count, `load_val` and `count`.
- `PRE_W`, default 8: width of the prescaler compare value.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `load`  in  1  when high, `count` (and the reload register) take `load_val`.
- `load_val`  in  WIDTH  value to load.
- `prescale`  in  PRE_W  decrement occurs every `prescale`+1 RUN cycles; sampled every cycle.
- `start`  in  1  start or resume counting.
- `stop`  in  1  pause; a second stop cancels.
- `count`  out  WIDTH  current count value.
- `busy`  out  1  high when the state is not IDLE.
- `expire`  out  1  one-cycle pulse marking the 1→0 decrement.

## Operation
- State machine states are IDLE, RUN and HOLD. On reset: IDLE, `count`=0, reload=0, prescaler=0, `busy`=0, `expire`=0.
- Prescaler `pre_cnt` behaviour:
  - Increments every RUN cycle.
  - A tick occurs when `pre_cnt` >= `prescale`; `pre_cnt` then returns to 0.
  - Using >= means a lowered `prescale` never wraps the counter.
  - `pre_cnt` is held in HOLD and cleared in IDLE or on `load`.
- On a tick in RUN, `count` decrements by 1. It never decrements below 0 and never wraps.
- When a tick moves `count` from 1 to 0:
  - `expire` pulses.
  - The state goes to IDLE, unless auto-reload is compiled in (see Configuration).
- State transitions (`stop` has priority over `start`):
  - IDLE + `start` + effective count ≠ 0 → RUN. The effective count is `load_val` if `load` is high that cycle, otherwise `count`.
  - IDLE + `start` + effective count = 0 → stay IDLE, no `expire`.
  - RUN + `stop` → HOLD. RUN + `start` → no effect.
  - HOLD + `start` → RUN, resuming with the held `pre_cnt`. HOLD + `stop` → IDLE, `pre_cnt` cleared, `count` retained.
  - IDLE + `stop` → no effect.
- `load` is accepted in any state and does not change the state.
  - In RUN, loading 0 forces IDLE with no `expire`.
  - A `load` on the same cycle as a tick wins; the tick is discarded.
- `expire` is never high for two consecutive cycles unless auto-reload is enabled with reload=1 and `prescale`=0.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- If `start` is sampled at edge k with count N and `prescale` P:
  - Ticks occur at edges k+j·(P+1), for j = 1..N.
  - `count` reads 0 and `expire` is high in the cycle after edge k+N·(P+1).
  - `busy` falls on that same edge (non-reload build).
- `stop` sampled at edge m: no tick is taken at edge m+1 or after. Ticks already committed at edge m stand.
- Reset asserted mid-count returns all state to reset values immediately (asynchronously). Counting restarts only after a fresh `start`.

## Configuration
- Macro: `DEC_TIMER_AUTO_RELOAD_EN`.
- Defined:
  - At expiry, `count` takes the reload register value in the same edge, the state stays RUN and `expire` still pulses.
  - `count` never reads 0 while running.
  - If the reload value is 0, the timer goes to IDLE instead.
- Undefined:
  - The reload register is not implemented.
  - Expiry always goes to IDLE with `count`=0.

## Structure
- Package `dec_timer_pkg`:
  - State enum `dec_timer_state_t` {IDLE, RUN, HOLD}.
  - Default-width localparams.
- Sub-module `dec_timer_prescaler`:
  - Owns `pre_cnt` and the >= compare.
  - Inputs: `run`, `hold`, `clear`, `prescale`. Output: `tick`.
- Top module: FSM, count and reload registers, `expire` register.

## Test plan
- Reset mid-RUN with `count`=5 → next cycle `count`=0, `busy`=0, `expire`=0; a `start` with no `load` stays IDLE.
- `load_val`=3, `prescale`=0, `start` at edge 0 → `count` reads 2, 1, 0 after edges 1, 2, 3; `expire` high exactly one cycle after edge 3; `busy`=0.
- `load_val`=2, `prescale`=4, `start` → ticks at edges 5 and 10; `stop` at edge 7, `start` at edge 12 → the remaining tick lands at edge 15 with `expire`.
- `prescale` dropped from 10 to 2 while `pre_cnt`=6 → tick on the next edge, then every 3 cycles, with no wrap.
- `load`=1 with `load_val`=0 while RUN at `count`=4 → IDLE, `count`=0, no `expire`. `start` with `load`, `load_val`=7 in IDLE → RUN with `count`=7.
- With `DEC_TIMER_AUTO_RELOAD_EN`: `load_val`=2, `prescale`=1 → `expire` every 4 cycles, `count` alternating 2, 1, `busy` stays 1. Reload 0 → IDLE after the first expiry.
